uart_rx: RTL and testbench
==========================

# uart_rx

Serial 8N1 UART receiver for the Master_Control host link. It is the receive-side counterpart of the shared baud pulse generator. It synchronises the asynchronous `rx` line and detects a start bit. It samples each bit at mid-bit using an internal baud counter that follows the same MAXCOUNT/RESETVAL scheme as the baud generator. Each received byte is presented to the command decoder with a one-cycle valid strobe, and framing errors are flagged.

## Interface
- `CLKFREQ`, 100000000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `MAXCOUNT`, CLKFREQ/BAUD (integer division), clock cycles per bit
- `RESETVAL`, MAXCOUNT/2 (integer division), cycles from start-bit detection to start-bit sample
- `DIM_CNT`, 16, baud counter width; MAXCOUNT must be at most 2^DIM_CNT

Ports:
- `clk`  input  1  system clock; all logic on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `rx`  input  1  asynchronous serial input; idles high
- `data`  output  8  last correctly framed byte; LSB is the first bit received
- `data_valid`  output  1  one-cycle strobe; `data` is updated in the same cycle
- `frame_err`  output  1  one-cycle strobe; stop bit was sampled low
- `busy`  output  1  high whenever the state is not IDLE

## Operation
- Synchroniser:
  - Two flip-flops on `rx`; their output is `rx_s`.
  - Both flip-flops reset to 1.
  - All decisions below use `rx_s` only.
- States: IDLE, START, DATA, STOP, BREAK. The baud counter `cnt` is DIM_CNT bits wide.
- IDLE:
  - When `rx_s`=0, go to START with `cnt`=0.
- START:
  - `cnt` increments each cycle.
  - At `cnt`==RESETVAL-1, sample `rx_s`.
  - If the sample is 0, go to DATA with `cnt`=0 and bit index 0.
  - If the sample is 1, it is a false start: go to IDLE with no strobe.
- DATA:
  - `cnt` increments each cycle.
  - At `cnt`==MAXCOUNT-1, shift `rx_s` into the shift register (LSB first), set `cnt`=0 and increment the bit index.
  - After the 8th sample, go to STOP.
- STOP:
  - At `cnt`==MAXCOUNT-1, sample `rx_s`.
  - If the sample is 1: load `data` from the shift register, pulse `data_valid`, and go to IDLE.
  - If the sample is 0: leave `data` unchanged, pulse `frame_err`, and go to BREAK.
- BREAK:
  - Wait until `rx_s`=1, then go to IDLE.
  - A held-low line therefore never retriggers a reception.
- `data_valid` and `frame_err` are mutually exclusive. Each is high for exactly one cycle per frame.
- Reset:
  - `rst` takes priority over everything, including mid-frame.
  - On reset: state=IDLE, `cnt`=0, shift register=0, `data`=0, `data_valid`=0, `frame_err`=0, `busy`=0, synchroniser=1.
  - A frame in progress is discarded and no strobe is issued.
- `busy` is decoded from the registered state, with no extra delay.

## Timing
- Edge to IDLE exit:
  - A falling edge on `rx` reaches `rx_s` after 2 clock edges.
  - The state enters START on the next edge.
- Cycle numbering: cycle 0 is the first cycle in START (`cnt`=0).
  - Start-bit sample at cycle RESETVAL-1.
  - Data bit k (k=0..7) sampled at cycle RESETVAL+(k+1)·MAXCOUNT-1.
  - Stop-bit sample at cycle RESETVAL+9·MAXCOUNT-1.
  - `data_valid` or `frame_err` is high in cycle RESETVAL+9·MAXCOUNT, and the state is IDLE in that cycle.
- Back-to-back frames:
  - The receiver is in IDLE by mid-stop-bit.
  - A start edge arriving at the nominal stop-bit end is detected.
  - No idle time between frames is required.
- Tolerance: the total sampling error must stay within ±RESETVAL cycles per frame. This allows about ±5% baud mismatch.
- Integer truncation of MAXCOUNT is accepted. At the defaults, MAXCOUNT=868 and RESETVAL=434.

## Test plan
Scenarios 1–5 use `CLKFREQ`=16 and `BAUD`=1, giving MAXCOUNT=16 and RESETVAL=8.

1. Send byte 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 cycles/bit.
   - `data`=0xA5 and `data_valid` is high for exactly 1 cycle, 152 cycles after START is entered.
   - `frame_err` stays 0.
   - `busy` falls in the same cycle as `data_valid`.
2. Drive a glitch on `rx`: low for 5 cycles, then high.
   - START is entered, the sample at cycle 7 reads 1, and the state returns to IDLE.
   - No strobe occurs and `data` is unchanged.
3. Send 0x3C with the stop bit low, then hold `rx` low for 100 cycles.
   - `frame_err` pulses once and `data` keeps its old value.
   - The receiver stays in BREAK with `busy`=1 until `rx_s` goes high, with no second strobe.
4. Send 0x00 immediately followed by 0xFF, with no idle gap beyond one stop bit.
   - Two `data_valid` pulses occur, 160 cycles apart, carrying 0x00 then 0xFF.
5. Assert `rst` for 1 cycle during data bit 3, then send 0x81.
   - No strobe occurs for the aborted frame.
   - All outputs are 0 the cycle after reset.
   - 0x81 is then received correctly.
6. With default parameters, send 0x55 at 115200 baud and again at a ±4% skewed baud.
   - `data`=0x55 with `data_valid` in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Serial 8N1 receiver for the Master_Control host link. The asynchronous rx
// line is brought into the clock domain through a two-stage synchroniser. A
// low level starts a reception. The start bit is re-checked at mid-bit, and
// every later bit is sampled one bit period after the previous sample. The
// mid-bit counter uses the same MAXCOUNT/RESETVAL scheme as the shared baud
// pulse generator.
//
// Parameters:
//   CLKFREQ  - system clock frequency in Hz
//   BAUD     - line rate in bit/s
//   MAXCOUNT - clock cycles per bit (CLKFREQ/BAUD)
//   RESETVAL - cycles from start detection to the start-bit sample
//   DIM_CNT  - baud counter width; MAXCOUNT must fit in 2^DIM_CNT
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial input, idles high
//   data       out  last correctly framed byte, LSB received first
//   data_valid out  one-cycle strobe, data updated in the same cycle
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKFREQ  = 100000000,
    parameter int BAUD     = 115200,
    parameter int MAXCOUNT = CLKFREQ / BAUD,
    parameter int RESETVAL = MAXCOUNT / 2,
    parameter int DIM_CNT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Counter values at which the line is sampled.
    localparam logic [DIM_CNT-1:0] START_LAST = DIM_CNT'(RESETVAL - 1);
    localparam logic [DIM_CNT-1:0] BIT_LAST   = DIM_CNT'(MAXCOUNT - 1);
    localparam logic [DIM_CNT-1:0] CNT_ONE    = DIM_CNT'(1);

    logic               rx_meta_q;
    logic               rx_s_q;
    state_t             state_q;
    logic [DIM_CNT-1:0] cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic [7:0]         data_q;
    logic               data_valid_q;
    logic               frame_err_q;

    // Two-flop synchroniser. Both stages reset to the idle level, so leaving
    // reset never looks like a start bit.
    // NOTE: non-blocking assignments make each stage take the previous
    // stage's old value; blocking ones would collapse the chain to one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM with registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end

                START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A line that is high again at mid-start-bit was a glitch.
                        state_q   <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                STOP: begin
                    // Returning to IDLE at mid-stop-bit leaves half a bit of
                    // slack, so a back-to-back start edge is still caught.
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q       <= shift_q;
                            data_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                BREAK: begin
                    // A held-low line must go high before another start is
                    // accepted.
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx. dut_a runs at 16 cycles/bit (CLKFREQ=16,
// BAUD=1) for the functional scenarios. dut_b uses the default parameters for
// the line-rate and skew scenario. A negedge monitor timestamps busy edges and
// strobes, and the scenario tasks compare those records with hand-derived
// values.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       dv_a;
    logic       dv_b;
    logic       fe_a;
    logic       fe_b;
    logic       busy_a;
    logic       busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx #(
        .CLKFREQ(16),
        .BAUD   (1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_a),
        .data      (data_a),
        .data_valid(dv_a),
        .frame_err (fe_a),
        .busy      (busy_a)
    );

    uart_rx dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_b),
        .data      (data_b),
        .data_valid(dv_b),
        .frame_err (fe_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    // ------------------------------------------------------------------------
    int         cyc            = 0;
    int         busy_rise_cyc  = 0;
    int         busy_fall_cyc  = 0;
    int         dv_count_a     = 0;
    int         fe_count_a     = 0;
    int         last_dv_cyc    = 0;
    int         prev_dv_cyc    = 0;
    int         last_fe_cyc    = 0;
    logic [7:0] last_dv_data   = 8'h00;
    logic [7:0] prev_dv_data   = 8'h00;
    logic       busy_at_dv     = 1'b0;
    logic       busy_before_dv = 1'b0;
    int         dv_double      = 0;
    int         fe_double      = 0;
    int         both_count     = 0;
    logic       busy_prev      = 1'b0;
    logic       dv_prev        = 1'b0;
    logic       fe_prev        = 1'b0;
    int         dv_count_b     = 0;
    int         fe_count_b     = 0;
    logic [7:0] last_dv_data_b = 8'h00;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        busy_prev <= busy_a;
        dv_prev   <= dv_a;
        fe_prev   <= fe_a;
        if (busy_a === 1'b1 && busy_prev === 1'b0) busy_rise_cyc <= cyc;
        if (busy_a === 1'b0 && busy_prev === 1'b1) busy_fall_cyc <= cyc;
        if (dv_a === 1'b1) begin
            dv_count_a     <= dv_count_a + 1;
            prev_dv_cyc    <= last_dv_cyc;
            last_dv_cyc    <= cyc;
            prev_dv_data   <= last_dv_data;
            last_dv_data   <= data_a;
            busy_at_dv     <= busy_a;
            busy_before_dv <= busy_prev;
            if (dv_prev === 1'b1) dv_double <= dv_double + 1;
        end
        if (fe_a === 1'b1) begin
            fe_count_a  <= fe_count_a + 1;
            last_fe_cyc <= cyc;
            if (fe_prev === 1'b1) fe_double <= fe_double + 1;
        end
        if (dv_a === 1'b1 && fe_a === 1'b1) both_count <= both_count + 1;
        if (dv_b === 1'b1) begin
            dv_count_b     <= dv_count_b + 1;
            last_dv_data_b <= data_b;
        end
        if (fe_b === 1'b1) fe_count_b <= fe_count_b + 1;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int bit_cycles, input bit to_b);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (to_b) rx_b = bits[i];
            else      rx_a = bits[i];
            wait_cycles(bit_cycles);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        wait_cycles(3);
        n_checks++;
        if (data_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %0h expected 0", data_a);
        end
        n_checks++;
        if (dv_a !== 1'b0 || fe_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got dv=%b fe=%b expected 0 0", dv_a, fe_a);
        end
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got a=%b b=%b expected 0 0", busy_a, busy_b);
        end
        rst = 1'b0;
        wait_cycles(6);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b expected 0", busy_a);
        end
    endtask

    task automatic test_byte_a5();
        int dv0;
        int fe0;
        dv0 = dv_count_a;
        fe0 = fe_count_a;
        send_frame(8'hA5, 1'b1, 16, 1'b0);
        wait_cycles(8);
        #1;
        n_checks++;
        if (dv_count_a - dv0 !== 1) begin
            n_fail++;
            $display("FAIL a5_dv_count: got %0d expected 1", dv_count_a - dv0);
        end
        n_checks++;
        if (last_dv_data !== 8'hA5 || data_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL a5_data: got strobe=%0h out=%0h expected a5", last_dv_data, data_a);
        end
        n_checks++;
        if (last_dv_cyc - busy_rise_cyc !== 152) begin
            n_fail++;
            $display("FAIL a5_latency: got %0d expected 152", last_dv_cyc - busy_rise_cyc);
        end
        n_checks++;
        if (fe_count_a - fe0 !== 0) begin
            n_fail++;
            $display("FAIL a5_frame_err: got %0d expected 0", fe_count_a - fe0);
        end
        n_checks++;
        if (busy_at_dv !== 1'b0 || busy_before_dv !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_busy_fall: got at=%b before=%b expected 0 1", busy_at_dv, busy_before_dv);
        end
        n_checks++;
        if (dv_double !== 0) begin
            n_fail++;
            $display("FAIL a5_dv_width: got %0d long pulses expected 0", dv_double);
        end
    endtask

    task automatic test_false_start();
        int dv0;
        int fe0;
        dv0 = dv_count_a;
        fe0 = fe_count_a;
        rx_a = 1'b0;
        wait_cycles(5);
        rx_a = 1'b1;
        wait_cycles(20);
        #1;
        // Glitch enters START at cycle 0 and returns to IDLE after the cycle-7 sample.
        n_checks++;
        if (busy_fall_cyc - busy_rise_cyc !== 8) begin
            n_fail++;
            $display("FAIL glitch_busy_len: got %0d expected 8", busy_fall_cyc - busy_rise_cyc);
        end
        n_checks++;
        if (dv_count_a - dv0 !== 0 || fe_count_a - fe0 !== 0) begin
            n_fail++;
            $display("FAIL glitch_strobe: got dv=%0d fe=%0d expected 0 0",
                     dv_count_a - dv0, fe_count_a - fe0);
        end
        n_checks++;
        if (data_a !== 8'hA5 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_state: got data=%0h busy=%b expected a5 0", data_a, busy_a);
        end
    endtask

    task automatic test_framing_error();
        int dv0;
        int fe0;
        dv0 = dv_count_a;
        fe0 = fe_count_a;
        send_frame(8'h3C, 1'b0, 16, 1'b0);
        wait_cycles(100);
        #1;
        n_checks++;
        if (fe_count_a - fe0 !== 1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d expected 1", fe_count_a - fe0);
        end
        n_checks++;
        if (last_fe_cyc - busy_rise_cyc !== 152) begin
            n_fail++;
            $display("FAIL ferr_latency: got %0d expected 152", last_fe_cyc - busy_rise_cyc);
        end
        n_checks++;
        if (data_a !== 8'hA5 || dv_count_a - dv0 !== 0) begin
            n_fail++;
            $display("FAIL ferr_data: got data=%0h dv=%0d expected a5 0", data_a, dv_count_a - dv0);
        end
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_break_busy: got %b expected 1", busy_a);
        end
        rx_a = 1'b1;
        wait_cycles(6);
        #1;
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_release: got busy=%b expected 0", busy_a);
        end
        n_checks++;
        if (fe_count_a - fe0 !== 1 || dv_count_a - dv0 !== 0 || fe_double !== 0) begin
            n_fail++;
            $display("FAIL ferr_no_second: got fe=%0d dv=%0d dbl=%0d expected 1 0 0",
                     fe_count_a - fe0, dv_count_a - dv0, fe_double);
        end
    endtask

    task automatic test_back_to_back();
        int dv0;
        dv0 = dv_count_a;
        send_frame(8'h00, 1'b1, 16, 1'b0);
        send_frame(8'hFF, 1'b1, 16, 1'b0);
        wait_cycles(10);
        #1;
        n_checks++;
        if (dv_count_a - dv0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 2", dv_count_a - dv0);
        end
        n_checks++;
        if (last_dv_cyc - prev_dv_cyc !== 160) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 160", last_dv_cyc - prev_dv_cyc);
        end
        n_checks++;
        if (prev_dv_data !== 8'h00 || last_dv_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_data: got %0h,%0h expected 00,ff", prev_dv_data, last_dv_data);
        end
        n_checks++;
        if (both_count !== 0 || dv_double !== 0) begin
            n_fail++;
            $display("FAIL b2b_exclusive: got both=%0d dbl=%0d expected 0 0", both_count, dv_double);
        end
    endtask

    // Aborted byte 0xF8 keeps the line high from bit 3 on, so nothing after
    // the reset looks like a new start bit.
    task automatic test_reset_mid_frame();
        int dv0;
        int fe0;
        dv0 = dv_count_a;
        fe0 = fe_count_a;
        rx_a = 1'b0;
        wait_cycles(16 + 48);
        rx_a = 1'b1;
        wait_cycles(8);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        n_checks++;
        if (data_a !== 8'h00 || dv_a !== 1'b0 || fe_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs: got data=%0h dv=%b fe=%b busy=%b expected 0 0 0 0",
                     data_a, dv_a, fe_a, busy_a);
        end
        wait_cycles(7 + 80 + 20);
        #1;
        n_checks++;
        if (dv_count_a - dv0 !== 0 || fe_count_a - fe0 !== 0) begin
            n_fail++;
            $display("FAIL rst_abort_strobe: got dv=%0d fe=%0d expected 0 0",
                     dv_count_a - dv0, fe_count_a - fe0);
        end
        send_frame(8'h81, 1'b1, 16, 1'b0);
        wait_cycles(10);
        #1;
        n_checks++;
        if (dv_count_a - dv0 !== 1 || data_a !== 8'h81) begin
            n_fail++;
            $display("FAIL rst_recover: got dv=%0d data=%0h expected 1 81", dv_count_a - dv0, data_a);
        end
    endtask

    // 868 cycles/bit nominal, then +4% (903) and -4% (833).
    task automatic test_default_baud();
        int periods [3];
        int dv0;
        int fe0;
        periods = '{868, 903, 833};
        for (int i = 0; i < 3; i++) begin
            dv0 = dv_count_b;
            fe0 = fe_count_b;
            send_frame(8'h55, 1'b1, periods[i], 1'b1);
            wait_cycles(20);
            #1;
            n_checks++;
            if (dv_count_b - dv0 !== 1 || fe_count_b - fe0 !== 0) begin
                n_fail++;
                $display("FAIL baud_%0d_strobe: got dv=%0d fe=%0d expected 1 0",
                         periods[i], dv_count_b - dv0, fe_count_b - fe0);
            end
            n_checks++;
            if (last_dv_data_b !== 8'h55 || data_b !== 8'h55) begin
                n_fail++;
                $display("FAIL baud_%0d_data: got %0h expected 55", periods[i], data_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_a5();
        test_false_start();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_baud();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
